stdout_fifo: RTL and testbench
==============================

Name: stdout_fifo

Overview:
- Sits between the proc stdout output and the uart_tx transmitter.
- Replaces the single-byte stdout_en edge-detect and start-pulse logic with a byte FIFO plus a transmit handshake FSM.
- The CPU stalls only when the FIFO is nearly full, not for every UART byte.
- Single clock domain: the core clock; proc and uart_tx both run on clk.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  byte from proc stdout; valid while in_en is high.
- in_en  in  1  proc stdout_en level; each 0->1 transition marks one new byte.
- cpu_en  out  1  proc enable; low stalls the CPU.
- tx_data  out  8  byte to uart_tx data.
- tx_start  out  1  uart_tx start request.
- tx_ready  in  1  uart_tx ready; high = idle.
- count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; a byte was dropped on a full FIFO.

Behaviour:
- Reset values (synchronous, applied at the clock edge where reset=1): count=0, pointers=0, tx_start=0, tx_data=0, overflow=0, cpu_en=1, in_en_q=0, FSM=IDLE.
- Push detect: in_en_q registers in_en each cycle. push = in_en & ~in_en_q. A level held high for many cycles is one byte only. in_data is sampled in the push cycle.
- Push when count==DEPTH: byte dropped, overflow<=1, count unchanged. overflow clears only on reset.
- cpu_en = (count < DEPTH-1), combinational from registered count. This leaves one slot of slack for a byte already in flight from proc.
- Pop occurs in IDLE when count!=0 and tx_ready==1. The head byte goes to tx_data, the read pointer advances, FSM->START.
- Simultaneous push and pop: both happen and count is unchanged. Push on full with simultaneous pop is accepted, not dropped.
- Pointers wrap modulo DEPTH. count is a separate AW+1-bit counter.
- FSM:
  - IDLE: tx_start=0; wait for the pop condition.
  - START: tx_start=1 and tx_data held stable. Stay until tx_ready==0 is sampled (uart acknowledged), then go to BUSY. No timeout.
  - BUSY: tx_start=0. When tx_ready==1, go to IDLE.
- Latency: the first byte into an empty FIFO with the UART idle gets tx_start high 2 cycles after the in_en rising edge.
- Minimum spacing between consecutive tx_start assertions is 3 cycles plus the UART frame time.
- Reset mid-transfer: the FSM aborts to IDLE and the FIFO empties. The byte in uart_tx completes on its own.

Optional Feature:
- Macro: STDOUT_CRLF_EN.
- Defined:
  - A popped 0x0A is sent as 0x0D followed by 0x0A.
  - On pop of 0x0A, tx_data=0x0D and a crlf_pending flag is set.
  - On the return to IDLE with crlf_pending set, 0x0A is sent next without a pop, ignoring count, and the flag is cleared.
  - Reset clears crlf_pending.
- Undefined: bytes pass through unmodified and the crlf_pending logic is absent.

Decomposition:
- Package verifuck_pkg holds:
  - the FSM state typedef {IDLE, START, BUSY};
  - localparams ASCII_CR=8'h0D and ASCII_LF=8'h0A.
- Sub-module sync_fifo (DEPTH, WIDTH; push/pop/full/empty/count) holds storage and pointers.
- stdout_fifo keeps the edge detect, FSM, cpu_en and overflow logic.
- sync_fifo is reusable for a future stdin path on uart_rx_pin.

Test Plan:
- Single byte: in_en 0->1 with in_data=0x48, tx_ready=1 -> tx_start high 2 cycles later with tx_data=0x48. tx_start stays high until tx_ready is driven 0; count returns to 0.
- Held level: in_en high for 10 cycles with in_data=0x41 -> exactly one tx_start, count peaks at 1.
- Backpressure: tx_ready held 0, 15 rising edges with DEPTH=16 -> cpu_en falls when count reaches 15. A 16th edge gives count=16; a 17th sets overflow=1 with count=16.
- Simultaneous: count=16, tx_ready=1, push on the cycle IDLE pops -> no overflow, count stays 16.
- CRLF (macro defined): push 0x0A -> tx_data sequence 0x0D then 0x0A, two handshakes, count back to 0. Macro undefined -> a single 0x0A.
- Reset mid-operation: reset=1 for 1 cycle while in START with count=5 -> next cycle tx_start=0, count=0, cpu_en=1, overflow=0.

Source files
------------

// File: rtl/verifuck_pkg.sv
// Shared types and constants for the verifuck stdout path: transmit FSM states and ASCII codes.
package verifuck_pkg;

   typedef logic [1:0] tx_state_t;

   localparam tx_state_t IDLE  = 2'd0;
   localparam tx_state_t START = 2'd1;
   localparam tx_state_t BUSY  = 2'd2;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth, wrapping pointers and a separate occupancy counter.
// Generic enough to serve a future stdin path as well as stdout.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   generate
      if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("sync_fifo: DEPTH must be a power of two and at least 4");
      end
   endgenerate

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A push into a full FIFO still lands when the same cycle frees the head slot.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_ONE;
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/stdout_fifo.sv
// Buffers proc stdout bytes and feeds them to uart_tx through a start/ready handshake FSM.
// Optional STDOUT_CRLF_EN: every LF leaves the FIFO as a CR followed by an LF.
module stdout_fifo
   import verifuck_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              in_data,
   input  logic                    in_en,
   output logic                    cpu_en,
   output logic [7:0]              tx_data,
   output logic                    tx_start,
   input  logic                    tx_ready,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CPU_LIMIT = (AW+1)'(DEPTH - 1);

   logic            in_en_q, in_en_d;
   tx_state_t       state_q, state_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            overflow_q, overflow_d;
`ifdef STDOUT_CRLF_EN
   logic            crlf_pending_q, crlf_pending_d;
`endif

   logic            push;
   logic            pop;
   logic [7:0]      fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic [AW:0]     fifo_count;

   // proc holds stdout_en as a level, so only its rising edge carries a new byte.
   assign push = in_en & ~in_en_q;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // One slot of slack absorbs a byte proc may already have in flight when stalled.
   assign cpu_en   = (fifo_count < CPU_LIMIT);
   assign count    = fifo_count;
   assign tx_start = (state_q == START);
   assign tx_data  = tx_data_q;
   assign overflow = overflow_q;

   always_comb begin
      in_en_d   = in_en;
      state_d   = state_q;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
`ifdef STDOUT_CRLF_EN
      crlf_pending_d = crlf_pending_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef STDOUT_CRLF_EN
            if (crlf_pending_q && tx_ready) begin
               tx_data_d      = ASCII_LF;
               crlf_pending_d = 1'b0;
               state_d        = START;
            end else
`endif
            if (tx_ready && !fifo_empty) begin
               pop     = 1'b1;
               state_d = START;
`ifdef STDOUT_CRLF_EN
               if (fifo_rdata == ASCII_LF) begin
                  tx_data_d      = ASCII_CR;
                  crlf_pending_d = 1'b1;
               end else begin
                  tx_data_d = fifo_rdata;
               end
`else
               tx_data_d = fifo_rdata;
`endif
            end
         end
         START: begin
            if (!tx_ready) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (tx_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      overflow_d = overflow_q | (push & fifo_full & ~pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_en_q    <= 1'b0;
         state_q    <= IDLE;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         in_en_q    <= in_en_d;
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef STDOUT_CRLF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         crlf_pending_q <= 1'b0;
      end else begin
         crlf_pending_q <= crlf_pending_d;
      end
   end
`endif

endmodule

// File: tb/tb_stdout_fifo.sv
// Self-checking bench for stdout_fifo: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model (honours STDOUT_CRLF_EN).
module tb_stdout_fifo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    in_data;
   logic          in_en;
   logic          cpu_en;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          tx_ready;
   logic [AW:0]   count;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   stdout_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_en    (in_en),
      .cpu_en   (cpu_en),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_ready (tx_ready),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: a byte queue plus the handshake phase the UART link is in.
   typedef enum int {M_WAITING, M_REQUESTING, M_SENDING} mphase_t;
   logic [7:0] m_q[$];
   mphase_t    m_phase;
   logic       m_prev_en;
   logic       m_ovf;
   logic       m_lf_owed;
   logic [7:0] m_data;

   task automatic modelStep(input logic rst, input logic en, input logic [7:0] d, input logic rdy);
      logic       is_new;
      logic [7:0] b;
      if (rst) begin
         m_q.delete();
         m_phase   = M_WAITING;
         m_prev_en = 1'b0;
         m_ovf     = 1'b0;
         m_lf_owed = 1'b0;
         m_data    = 8'h00;
         return;
      end
      is_new    = en && !m_prev_en;
      m_prev_en = en;
      case (m_phase)
         M_WAITING: begin
`ifdef STDOUT_CRLF_EN
            if (m_lf_owed && rdy) begin
               m_data    = 8'h0A;
               m_lf_owed = 1'b0;
               m_phase   = M_REQUESTING;
            end else
`endif
            if (rdy && m_q.size() > 0) begin
               b = m_q.pop_front();
               m_data = b;
`ifdef STDOUT_CRLF_EN
               if (b == 8'h0A) begin
                  m_data    = 8'h0D;
                  m_lf_owed = 1'b1;
               end
`endif
               m_phase = M_REQUESTING;
            end
         end
         M_REQUESTING: if (!rdy) m_phase = M_SENDING;
         M_SENDING:    if (rdy)  m_phase = M_WAITING;
         default:      m_phase = M_WAITING;
      endcase
      if (is_new) begin
         if (m_q.size() < DEPTH) m_q.push_back(d);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic checkOne(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] d, input logic rdy);
      reset    = rst;
      in_en    = en;
      in_data  = d;
      tx_ready = rdy;
      modelStep(rst, en, d, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, ".count"},    int'(count),    m_q.size());
      checkOne({tag, ".tx_start"}, int'(tx_start), (m_phase == M_REQUESTING) ? 1 : 0);
      checkOne({tag, ".tx_data"},  int'(tx_data),  int'(m_data));
      checkOne({tag, ".cpu_en"},   int'(cpu_en),   (m_q.size() < DEPTH - 1) ? 1 : 0);
      checkOne({tag, ".overflow"}, int'(overflow), int'(m_ovf));
   endtask

   task automatic pushByte(input logic [7:0] d, input logic rdy, input string tag);
      applyStimulus(1'b0, 1'b1, d, rdy);
      checkOutput(tag);
      applyStimulus(1'b0, 1'b0, d, rdy);
      checkOutput(tag);
   endtask

   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] d;
      logic       rdy;
      int         e_count;
      logic       e_start;
      logic [7:0] e_data;
      logic       e_cpu;
      logic       e_ovf;
   } vec_t;

   vec_t vecs[12];

   initial begin
      // Single byte with full handshake, then a level held high that must count once.
      vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 8'h48, 1'b1, 1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 8'h48, 1'b1, 0, 1'b1, 8'h48, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h48, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h48, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h48, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h48, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 8'h41, 1'b1, 1, 1'b0, 8'h48, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'h41, 1'b1, 0, 1'b1, 8'h41, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 8'h41, 1'b0, 0, 1'b0, 8'h41, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'h41, 1'b1, 0, 1'b0, 8'h41, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 8'h41, 1'b1, 0, 1'b0, 8'h41, 1'b1, 1'b0};

      reset = 1'b1; in_en = 1'b0; in_data = 8'h00; tx_ready = 1'b1;
      modelStep(1'b1, 1'b0, 8'h00, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].rdy);
         checkOne($sformatf("vec%0d.count", i),    int'(count),    vecs[i].e_count);
         checkOne($sformatf("vec%0d.tx_start", i), int'(tx_start), int'(vecs[i].e_start));
         checkOne($sformatf("vec%0d.tx_data", i),  int'(tx_data),  int'(vecs[i].e_data));
         checkOne($sformatf("vec%0d.cpu_en", i),   int'(cpu_en),   int'(vecs[i].e_cpu));
         checkOne($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].e_ovf));
         checkOutput($sformatf("vec%0d.model", i));
      end

      // Backpressure: UART never ready, fill past capacity.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 1; k <= 17; k++) begin
         pushByte(8'(k), 1'b0, "bp");
         if (k == 14) checkOne("bp14.cpu_en", int'(cpu_en), 1);
         if (k == 15) begin
            checkOne("bp15.cpu_en", int'(cpu_en), 0);
            checkOne("bp15.count", int'(count), 15);
         end
         if (k == 16) begin
            checkOne("bp16.count", int'(count), 16);
            checkOne("bp16.overflow", int'(overflow), 0);
         end
         if (k == 17) begin
            checkOne("bp17.count", int'(count), 16);
            checkOne("bp17.overflow", int'(overflow), 1);
         end
      end

      // Push on a full FIFO in the same cycle the FSM pops: accepted, not dropped.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 1; k <= 16; k++) pushByte(8'(k), 1'b0, "sim_fill");
      checkOne("sim_fill.count", int'(count), 16);
      applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
      checkOutput("sim_pop");
      checkOne("sim.count", int'(count), 16);
      checkOne("sim.overflow", int'(overflow), 0);
      checkOne("sim.tx_start", int'(tx_start), 1);
      checkOne("sim.tx_data", int'(tx_data), 8'h01);
      for (int c = 0; c < 100; c++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, (c % 2 == 1) ? 1'b1 : 1'b0);
         checkOutput("drain");
      end
      checkOne("drain.count", int'(count), 0);

      // LF handling: CR then LF with CRLF expansion, a lone LF otherwise.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h0A, 1'b1);
      checkOne("lf.count", int'(count), 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOne("lf.start1", int'(tx_start), 1);
`ifdef STDOUT_CRLF_EN
      checkOne("lf.data1", int'(tx_data), 8'h0D);
`else
      checkOne("lf.data1", int'(tx_data), 8'h0A);
`endif
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("lf.back_idle");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
`ifdef STDOUT_CRLF_EN
      checkOne("lf.start2", int'(tx_start), 1);
      checkOne("lf.data2", int'(tx_data), 8'h0A);
`else
      checkOne("lf.start2", int'(tx_start), 0);
`endif
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOne("lf.count_end", int'(count), 0);
      checkOutput("lf.end");

      // Reset while START is asserted with five bytes still queued.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 6; k++) pushByte(8'h30 + 8'(k), 1'b0, "rst_fill");
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOne("rst.pre_start", int'(tx_start), 1);
      checkOne("rst.pre_count", int'(count), 5);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      checkOne("rst.tx_start", int'(tx_start), 0);
      checkOne("rst.count", int'(count), 0);
      checkOne("rst.cpu_en", int'(cpu_en), 1);
      checkOne("rst.overflow", int'(overflow), 0);

      // Randomized traffic with slowly varying UART readiness.
      begin
         int thresh;
         logic [7:0] d;
         thresh = 50;
         for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) thresh = int'($urandom_range(5, 95));
            d = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            applyStimulus(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                          1'($urandom_range(0, 1)), d,
                          (int'($urandom_range(0, 99)) < thresh) ? 1'b1 : 1'b0);
            checkOutput("rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
